// File: rtl/bus_transfer_ctrl.sv
// Source side of the 16-bit internal data bus: drives one register onto the bus,
// then pulses a one-hot load/move enable into the destination for one slow-clock tick.
module bus_transfer_ctrl #(
  parameter int N_REGS = 8,
  parameter int SEL_W  = 3
) (
  input  logic                  clk,
  input  logic                  aclr_l,
  input  logic                  slow_clock_strb,
  input  logic                  req,
  input  logic [SEL_W-1:0]      src_sel,
  input  logic [SEL_W-1:0]      dst_sel,
  input  logic                  mov_mode,
  input  logic                  abort,
  input  logic [16*N_REGS-1:0]  src_data,
  output logic [15:0]           bus,
  output logic                  bus_valid,
  output logic [N_REGS-1:0]     in_en,
  output logic [N_REGS-1:0]     mov_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, DRIVE, LOAD, ACK} state_t;

  state_t              state, state_next;
  logic [SEL_W-1:0]    dst_q, dst_next;
  logic                mov_q, mov_next;
  logic [15:0]         bus_next;
  logic                bus_valid_next, busy_next, done_next, err_next;
  logic [N_REGS-1:0]   in_en_next, mov_en_next, dst_onehot;
  logic [15:0]         src_word;
  logic                sel_ok;

  // Both selectors widened to int so the range check stays meaningful when N_REGS == 2**SEL_W.
  assign sel_ok = (int'(src_sel) < N_REGS) && (int'(dst_sel) < N_REGS);

  assign dst_onehot = {{(N_REGS-1){1'b0}}, 1'b1} << dst_q;

  always_comb begin
    src_word = 16'h0000;
    for (int i = 0; i < N_REGS; i++) begin
      if (src_sel == SEL_W'(i)) src_word = src_data[16*i +: 16];
    end
  end

  // State and output registers; every update is qualified by the slow-clock strobe.
  always_ff @(posedge clk or negedge aclr_l) begin
    if (!aclr_l) begin
      state     <= IDLE;
      dst_q     <= '0;
      mov_q     <= 1'b0;
      bus       <= 16'h0000;
      bus_valid <= 1'b0;
      in_en     <= '0;
      mov_en    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (slow_clock_strb) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, like real flops.
      state     <= state_next;
      dst_q     <= dst_next;
      mov_q     <= mov_next;
      bus       <= bus_next;
      bus_valid <= bus_valid_next;
      in_en     <= in_en_next;
      mov_en    <= mov_en_next;
      busy      <= busy_next;
      done      <= done_next;
      err       <= err_next;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE:    if (req && sel_ok) state_next = DRIVE;
      DRIVE:   state_next = abort ? IDLE : LOAD;
      LOAD:    state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dst_next       = dst_q;
    mov_next       = mov_q;
    bus_next       = bus;
    bus_valid_next = bus_valid;
    busy_next      = busy;
    in_en_next     = '0;
    mov_en_next    = '0;
    done_next      = 1'b0;
    err_next       = 1'b0;
    unique case (state)
      IDLE: begin
        if (req && !sel_ok) begin
          err_next = 1'b1;
        end else if (req) begin
          bus_next       = mov_mode ? {8'h00, src_word[7:0]} : src_word;
          bus_valid_next = 1'b1;
          busy_next      = 1'b1;
          dst_next       = dst_sel;
          mov_next       = mov_mode;
        end
      end
      DRIVE: begin
        if (abort) begin
          bus_valid_next = 1'b0;
          busy_next      = 1'b0;
        end else if (mov_q) begin
          mov_en_next = dst_onehot;
        end else begin
          in_en_next = dst_onehot;
        end
      end
      LOAD: begin
        // Committed: abort is not looked at here.
        bus_valid_next = 1'b0;
        busy_next      = 1'b0;
        done_next      = 1'b1;
      end
      ACK: ;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Bench for bus_transfer_ctrl: directed scenarios plus random traffic, all checked
// against a tick-timeline reference model of the transfer protocol.
module tb_bus_transfer_ctrl;

  localparam int N  = 6;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            aclr_l, strb, req, mov_mode, abort;
  logic [SW-1:0]   src_sel, dst_sel;
  logic [16*N-1:0] src_data;
  logic [15:0]     bus;
  logic            bus_valid, busy, done, err;
  logic [N-1:0]    in_en, mov_en;

  bus_transfer_ctrl #(.N_REGS(N), .SEL_W(SW)) dut (
    .clk(clk), .aclr_l(aclr_l), .slow_clock_strb(strb), .req(req),
    .src_sel(src_sel), .dst_sel(dst_sel), .mov_mode(mov_mode), .abort(abort),
    .src_data(src_data), .bus(bus), .bus_valid(bus_valid), .in_en(in_en),
    .mov_en(mov_en), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: ticks elapsed since acceptance (0 = no transfer in flight).
  int          age;
  logic [15:0] m_bus;
  int          m_dst;
  bit          m_mov;
  bit          m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] reg_val(input int i);
    return src_data[16*i +: 16];
  endfunction

  task automatic set_reg(input int i, input logic [15:0] v);
    src_data[16*i +: 16] = v;
  endtask

  task automatic model_reset();
    age = 0; m_bus = 16'h0000; m_dst = 0; m_mov = 0; m_err = 0;
  endtask

  task automatic model_tick(input bit r, input int s, input int d, input bit mv,
                            input bit ab, input logic [15:0] word);
    m_err = 0;
    if (age == 0) begin
      if (r) begin
        if (s >= N || d >= N) m_err = 1;
        else begin
          m_bus = mv ? {8'h00, word[7:0]} : word;
          m_dst = d; m_mov = mv; age = 1;
        end
      end
    end else if (age == 1) age = ab ? 0 : 2;
    else if (age == 2) age = 3;
    else age = 0;
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] onehot;
    onehot = 32'd1 << m_dst;
    check({tag, ".bus"},       bus,       m_bus);
    check({tag, ".bus_valid"}, bus_valid, (age == 1 || age == 2));
    check({tag, ".busy"},      busy,      (age == 1 || age == 2));
    check({tag, ".in_en"},     in_en,     (age == 2 && !m_mov) ? onehot : 32'd0);
    check({tag, ".mov_en"},    mov_en,    (age == 2 &&  m_mov) ? onehot : 32'd0);
    check({tag, ".done"},      done,      age == 3);
    check({tag, ".err"},       err,       m_err);
  endtask

  // One clock: inputs as seen before the edge feed the model, outputs sampled 1 ns after.
  task automatic step(input string tag);
    bit s_strb, s_req, s_mov, s_abort;
    int s_src, s_dst;
    logic [15:0] s_word;
    s_strb = strb; s_req = req; s_mov = mov_mode; s_abort = abort;
    s_src = int'(src_sel); s_dst = int'(dst_sel);
    s_word = (s_src < N) ? reg_val(s_src) : 16'h0000;
    @(posedge clk); #1;
    if (s_strb) model_tick(s_req, s_src, s_dst, s_mov, s_abort, s_word);
    compare_all(tag);
  endtask

  task automatic request(input int s, input int d, input bit mv);
    req = 1; src_sel = SW'(s); dst_sel = SW'(d); mov_mode = mv;
  endtask

  initial begin
    int done_count;
    aclr_l = 0; strb = 1; req = 0; mov_mode = 0; abort = 0;
    src_sel = '0; dst_sel = '0; src_data = '0;
    model_reset();
    #1; compare_all("reset_init");
    @(posedge clk); #1;
    aclr_l = 1;
    step("idle");

    // Full 16-bit load
    set_reg(2, 16'hBEEF);
    request(2, 5, 0);
    step("full_t0"); check("full_t0_bus", bus, 16'hBEEF);
    req = 0; src_sel = 3'd0; set_reg(2, 16'h0000);
    step("full_t1"); check("full_t1_in_en", in_en, 32'b10_0000);
    step("full_t2"); check("full_t2_done", done, 1);
    step("full_t3");

    // Byte move, zero-extended low byte
    set_reg(1, 16'h12A7);
    request(1, 3, 1);
    step("byte_t0"); check("byte_t0_bus", bus, 16'h00A7);
    req = 0;
    step("byte_t1"); check("byte_t1_mov_en", mov_en, 32'b00_1000);
    check("byte_t1_in_en", in_en, 0);
    step("byte_t2"); step("byte_t3");

    // Abort in DRIVE cancels, abort in LOAD is ignored
    request(4, 0, 0); step("abort1_t0");
    req = 0; abort = 1; step("abort1_t1"); check("abort1_busy", busy, 0);
    abort = 0; step("abort1_t2"); check("abort1_no_done", done, 0);
    request(0, 4, 0); step("abort2_t0");
    req = 0; step("abort2_t1");
    abort = 1; step("abort2_t2"); check("abort2_done", done, 1);
    abort = 0; step("abort2_t3");

    // Strobe held low mid-DRIVE freezes everything
    request(5, 1, 1); step("gate_t0");
    req = 0; strb = 0;
    repeat (10) step("gate_hold");
    strb = 1; step("gate_t1"); check("gate_t1_mov_en", mov_en, 32'b00_0010);
    step("gate_t2"); step("gate_t3");

    // Out-of-range selectors are rejected
    request(1, 7, 0); step("rej_dst"); check("rej_dst_err", err, 1);
    request(6, 2, 0); step("rej_src");
    req = 0; step("rej_clear"); check("rej_clear_err", err, 0);

    // REQ held high: one transfer per IDLE acceptance
    request(3, 3, 0); done_count = 0;
    for (int i = 0; i < 8; i++) begin
      step("held");
      if (done) done_count++;
    end
    check("held_done_count", done_count, 2);
    req = 0; step("held_end");

    // Reset asserted during LOAD drops enables at once
    request(2, 4, 0); step("rst_t0");
    req = 0; step("rst_t1"); check("rst_load_en", in_en, 32'b01_0000);
    #2 aclr_l = 0; model_reset();
    #1 compare_all("rst_async");
    @(posedge clk); #1; compare_all("rst_hold");
    aclr_l = 1;
    repeat (3) step("rst_after");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      src_data = {$urandom, $urandom, $urandom};
      strb     = ($urandom_range(0, 4) != 0);
      req      = $urandom_range(0, 1);
      mov_mode = $urandom_range(0, 1);
      abort    = ($urandom_range(0, 3) == 0);
      src_sel  = ($urandom_range(0, 7) == 0) ? SW'($urandom_range(6, 7)) : SW'($urandom_range(0, 5));
      dst_sel  = ($urandom_range(0, 7) == 0) ? SW'($urandom_range(6, 7)) : SW'($urandom_range(0, 5));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
